// File: rtl/temp_buffer_ctrl_if.sv
// temp_buffer_ctrl_if
//   Groups the controller's request/handshake signals. The bench or upstream
//   logic connects through the master modport; temp_buffer_ctrl uses the
//   slave modport.
//   start      : one-cycle request to run one load/read/transfer/drain sequence
//   cfg_stride : stride value, captured when a start is accepted
//   in_valid   : pixel on in_data is valid
//   in_data    : signed pixel to load
//   in_ready   : controller accepts in_data this cycle
//   busy       : sequence in progress
//   done       : one-cycle completion pulse
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

interface temp_buffer_ctrl_if #(
  parameter int XLEN = `CNN_XLEN
);
  logic                   start;
  logic                   cfg_stride;
  logic                   in_valid;
  logic signed [XLEN-1:0] in_data;
  logic                   in_ready;
  logic                   busy;
  logic                   done;

  modport master (
    output start, cfg_stride, in_valid, in_data,
    input  in_ready, busy, done
  );

  modport slave (
    input  start, cfg_stride, in_valid, in_data,
    output in_ready, busy, done
  );
endinterface

// File: rtl/temp_buffer_ctrl.sv
// temp_buffer_ctrl
//   Sequencer for temp_buffer. On an accepted start it issues one clean
//   command, loads ROW_LEN pixels through a valid/ready handshake, reads the
//   row buffer for ROW_LEN cycles, transfers into the column buffer for
//   ROW_LEN cycles, drains the column buffer for DRAIN_LEN cycles and then
//   pulses done.
//   clk      : clock, all state changes on its rising edge
//   reset    : synchronous reset, active low
//   ctl      : request/handshake bundle (temp_buffer_ctrl_if.slave)
//   temp_pk  : registered command packet to temp_buffer
//   rd_valid : temp_buffer output carries read data this cycle
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package temp_buffer_pkg;
  localparam int CNN_XLEN = `CNN_XLEN;

  typedef enum logic [1:0] {
    NO_WR   = 2'd0,
    WR_DATA = 2'd1,
    WR_BUF  = 2'd2
  } wr_mode_t;

  typedef struct packed {
    logic                       clean;
    logic                       stride;
    wr_mode_t                   wr_r;
    logic                       rd_r;
    wr_mode_t                   wr_c;
    logic                       rd_c;
    logic signed [CNN_XLEN-1:0] data_wr;
  } temp_buf_packet;
endpackage

module temp_buffer_ctrl
  import temp_buffer_pkg::*;
#(
  parameter int ROW_LEN   = 7,
  parameter int DRAIN_LEN = 6
) (
  input  logic                clk,
  input  logic                reset,
  temp_buffer_ctrl_if.slave   ctl,
  output temp_buf_packet      temp_pk,
  output logic                rd_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAN,
    FILL,
    ROW_RD,
    COL_XFER,
    COL_DRAIN,
    DONE
  } state_t;

  // Terminal counts: the phase counter runs 0..LEN-1 and is cleared on
  // every state entry, so it never wraps inside a phase.
  localparam logic [7:0] ROW_LAST   = 8'(ROW_LEN - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_LEN - 1);

  state_t         state_reg;
  logic [7:0]     cnt_reg;
  logic           done_reg;
  logic           hs;
  temp_buf_packet pk_next;

  assign ctl.in_ready = (state_reg == FILL);
  assign ctl.busy     = (state_reg != IDLE);
  assign ctl.done     = done_reg;
  assign hs           = ctl.in_valid & ctl.in_ready;

  // Command for the current cycle; it is registered onto temp_pk so the
  // buffer sees it one cycle after the state that produced it. The stride
  // field simply holds its value except at an accepted start.
  always_comb begin
    pk_next        = '0;
    pk_next.stride = temp_pk.stride;
    case (state_reg)
      IDLE: begin
        if (ctl.start) pk_next.stride = ctl.cfg_stride;
      end
      CLEAN: begin
        pk_next.clean = 1'b1;
      end
      FILL: begin
        if (hs) begin
          pk_next.wr_r    = WR_DATA;
          pk_next.wr_c    = WR_DATA;
          pk_next.data_wr = ctl.in_data;
        end
      end
      ROW_RD: begin
        pk_next.rd_r = 1'b1;
      end
      COL_XFER: begin
        pk_next.wr_c = WR_BUF;
        pk_next.rd_c = 1'b1;
      end
      COL_DRAIN: begin
        pk_next.rd_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      temp_pk   <= '0;
      rd_valid  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      temp_pk  <= pk_next;
      // temp_buffer answers a read one cycle after it sees the command.
      rd_valid <= temp_pk.rd_r | temp_pk.rd_c;
      done_reg <= (state_reg == DONE);

      case (state_reg)
        IDLE: begin
          if (ctl.start) begin
            state_reg <= CLEAN;
            cnt_reg   <= 8'd0;
          end
        end
        CLEAN: begin
          state_reg <= FILL;
          cnt_reg   <= 8'd0;
        end
        FILL: begin
          // Only real handshakes advance the load count.
          if (hs) begin
            if (cnt_reg == ROW_LAST) begin
              state_reg <= ROW_RD;
              cnt_reg   <= 8'd0;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end
        end
        ROW_RD: begin
          if (cnt_reg == ROW_LAST) begin
            state_reg <= COL_XFER;
            cnt_reg   <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        COL_XFER: begin
          if (cnt_reg == ROW_LAST) begin
            state_reg <= COL_DRAIN;
            cnt_reg   <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        COL_DRAIN: begin
          if (cnt_reg == DRAIN_LAST) begin
            state_reg <= DONE;
            cnt_reg   <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_buffer_ctrl.sv
// tb_temp_buffer_ctrl
//   Drives a per-cycle stimulus table (directed scenarios followed by a
//   random section) into temp_buffer_ctrl. As each cycle is driven, a
//   sequence-level model schedules the expected packets, done pulses and
//   per-cycle flags; a monitor on the falling edge pops and compares them.
module tb_temp_buffer_ctrl;
  import temp_buffer_pkg::*;

  localparam int ROW_LEN   = 7;
  localparam int DRAIN_LEN = 6;
  localparam int MAXC      = 2200;
  localparam int TAIL      = 160;

  logic           clk = 1'b0;
  logic           reset;
  temp_buf_packet temp_pk;
  logic           rd_valid;
  int             cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  temp_buffer_ctrl_if #(.XLEN(CNN_XLEN)) ctl ();

  temp_buffer_ctrl #(
    .ROW_LEN  (ROW_LEN),
    .DRAIN_LEN(DRAIN_LEN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ctl     (ctl),
    .temp_pk (temp_pk),
    .rd_valid(rd_valid)
  );

  // Stimulus table, one entry per cycle.
  bit                         t_rst    [MAXC];
  bit                         t_start  [MAXC];
  bit                         t_stride [MAXC];
  bit                         t_valid  [MAXC];
  logic signed [CNN_XLEN-1:0] t_data   [MAXC];

  // Expected per-cycle flags.
  bit e_busy   [MAXC];
  bit e_ready  [MAXC];
  bit e_rdv    [MAXC];
  bit e_stride [MAXC];

  typedef struct {
    int             cyc;
    temp_buf_packet pk;
  } exp_t;

  exp_t pk_q[$];
  int   done_q[$];
  int   busy_until = -1;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int c, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  task automatic push_pk(input int c, input temp_buf_packet p);
    exp_t x;
    x.cyc = c;
    x.pk  = p;
    pk_q.push_back(x);
    if ((p.rd_r | p.rd_c) && (c + 1 < MAXC)) e_rdv[c+1] = 1'b1;
  endtask

  // Schedules a whole sequence accepted at cycle s: one clean, ROW_LEN
  // handshaked writes, ROW_LEN row reads, ROW_LEN transfers, DRAIN_LEN
  // drain reads, done one cycle after the last command.
  task automatic launch(input int s);
    temp_buf_packet p;
    logic st;
    int c, n, h, e;
    st = t_stride[s];
    for (int k = s + 1; k < MAXC; k++) e_stride[k] = st;
    p = '0; p.stride = st; p.clean = 1'b1;
    push_pk(s + 2, p);
    c = s + 2;
    n = 0;
    while (n < ROW_LEN && c < MAXC - 1) begin
      e_ready[c] = 1'b1;
      if (t_valid[c]) begin
        p = '0; p.stride = st;
        p.wr_r = WR_DATA; p.wr_c = WR_DATA; p.data_wr = t_data[c];
        push_pk(c + 1, p);
        n++;
      end
      c++;
    end
    h = c - 1;
    for (int k = 1; k <= ROW_LEN; k++) begin
      p = '0; p.stride = st; p.rd_r = 1'b1;
      push_pk(h + 1 + k, p);
    end
    for (int k = 1; k <= ROW_LEN; k++) begin
      p = '0; p.stride = st; p.wr_c = WR_BUF; p.rd_c = 1'b1;
      push_pk(h + ROW_LEN + 1 + k, p);
    end
    for (int k = 1; k <= DRAIN_LEN; k++) begin
      p = '0; p.stride = st; p.rd_c = 1'b1;
      push_pk(h + 2 * ROW_LEN + 1 + k, p);
    end
    e = h + 2 * ROW_LEN + DRAIN_LEN + 1;
    for (int k = s + 1; k <= e && k < MAXC; k++) e_busy[k] = 1'b1;
    done_q.push_back(e + 1);
    busy_until = e;
  endtask

  task automatic model_step(input int c);
    if (t_rst[c]) begin
      // Abort: everything scheduled after this edge disappears.
      while (pk_q.size() > 0 && pk_q[$].cyc > c) void'(pk_q.pop_back());
      while (done_q.size() > 0 && done_q[$] > c) void'(done_q.pop_back());
      for (int k = c + 1; k < MAXC; k++) begin
        e_busy[k] = 1'b0; e_ready[k] = 1'b0; e_rdv[k] = 1'b0; e_stride[k] = 1'b0;
      end
      busy_until = c;
    end else if (t_start[c] && c > busy_until) begin
      launch(c);
    end
  endtask

  task automatic drive(input int c);
    reset          = ~t_rst[c];
    ctl.start      = t_start[c];
    ctl.cfg_stride = t_stride[c];
    ctl.in_valid   = t_valid[c];
    ctl.in_data    = t_data[c];
  endtask

  // Monitor: compares everything the DUT presents in cycle cyc.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      temp_buf_packet idle_pk;
      exp_t x;
      bit exp_done;
      check("busy", cyc, ctl.busy, e_busy[cyc]);
      check("in_ready", cyc, ctl.in_ready, e_ready[cyc]);
      check("rd_valid", cyc, rd_valid, e_rdv[cyc]);
      check("stride", cyc, temp_pk.stride, e_stride[cyc]);
      if (pk_q.size() > 0 && pk_q[0].cyc == cyc) begin
        x = pk_q.pop_front();
        check("packet", cyc, 64'(temp_pk), 64'(x.pk));
      end else begin
        idle_pk = '0;
        idle_pk.stride = e_stride[cyc];
        check("idle_packet", cyc, 64'(temp_pk), 64'(idle_pk));
      end
      exp_done = 1'b0;
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        void'(done_q.pop_front());
        exp_done = 1'b1;
      end
      check("done", cyc, ctl.done, exp_done);
    end
  end

  initial begin
    // Background noise.
    for (int c = 0; c < MAXC; c++) begin
      t_rst[c]    = 1'b0;
      t_start[c]  = 1'b0;
      t_stride[c] = 1'($urandom_range(0, 1));
      t_valid[c]  = 1'($urandom_range(0, 1));
      t_data[c]   = CNN_XLEN'($urandom);
    end
    for (int c = 0; c < 3; c++) t_rst[c] = 1'b1;

    // Nominal run at 5 with data 1..7, plus a start during ROW_RD that
    // must be ignored (stride 0 requested, stride 1 must stay).
    t_start[5] = 1'b1; t_stride[5] = 1'b1;
    for (int k = 0; k < ROW_LEN; k++) begin
      t_valid[7+k] = 1'b1;
      t_data[7+k]  = CNN_XLEN'(k + 1);
    end
    t_start[17] = 1'b1; t_stride[17] = 1'b0;

    // Back-to-back start in the first idle cycle, gapped input.
    t_start[35] = 1'b1; t_stride[35] = 1'b0;
    for (int k = 0; k < 2 * ROW_LEN; k++) t_valid[37+k] = (k % 2 == 0);

    // Abort 12 cycles into a run, then a fresh nominal run.
    t_start[75] = 1'b1; t_stride[75] = 1'b1;
    for (int k = 0; k < ROW_LEN; k++) t_valid[77+k] = 1'b1;
    t_rst[87] = 1'b1;
    t_start[90] = 1'b1; t_stride[90] = 1'b1;
    for (int k = 0; k < ROW_LEN; k++) begin
      t_valid[92+k] = 1'b1;
      t_data[92+k]  = CNN_XLEN'(k + 1);
    end

    // Random section, then a quiet tail with in_valid held so the last
    // sequence finishes inside the table.
    for (int c = 130; c < MAXC - TAIL; c++) begin
      t_start[c] = ($urandom_range(0, 24) == 0);
      t_rst[c]   = ($urandom_range(0, 399) == 0);
    end
    for (int c = MAXC - TAIL; c < MAXC; c++) t_valid[c] = 1'b1;

    drive(0);
    model_step(0);
    for (int c = 1; c < MAXC; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      model_step(c);
    end
    @(negedge clk);
    #1;
    check("packets_left", MAXC, pk_q.size(), 0);
    check("done_left", MAXC, done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
